// File: rtl/memory_stage_ctrl.sv
// -----------------------------------------------------------------------------
// memory_stage_ctrl
//
// Memory stage of the 16-bit pipelined CPU, sitting between execute and
// writeback. It holds the Execute/Memory pipeline register (M), decodes the
// bank select onto NUM_BANKS synchronous RAMs that share one address and one
// write-data bus, waits out the RAM read latency on loads (stalling upstream),
// and produces the registered writeback bundle.
//
// Assumes ADDR_W <= DATA_W, because the bank address is the low part of the
// ALU result.
//
// Ports
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   ex_valid            execute stage presents an operation
//   ex_wbs              writeback select (1 = load data, 0 = calc data)
//   ex_wme              memory write enable (store), has priority over ex_wbs
//   ex_mm               bank select
//   ex_wm               calc mux select (1 = ex_write_data, 0 = ex_alu_result)
//   ex_ni               next-instruction flag, passed through
//   ex_alu_result       address / ALU result
//   ex_write_data       store data
//   flush               turn the op accepted at this edge into a bubble
//   stall               upstream must hold ex_* stable
//   bank_addr/wdata     shared address / store data to every bank
//   bank_we             one-hot bank write enable
//   bank_rdata          concatenated bank read data, bank k = slice k
//   wb_*                registered writeback bundle
// -----------------------------------------------------------------------------
module memory_stage_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int NUM_BANKS = 3,
  parameter int SEL_W     = 2,
  parameter int READ_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ex_valid,
  input  logic                        ex_wbs,
  input  logic                        ex_wme,
  input  logic [SEL_W-1:0]            ex_mm,
  input  logic                        ex_wm,
  input  logic                        ex_ni,
  input  logic [DATA_W-1:0]           ex_alu_result,
  input  logic [DATA_W-1:0]           ex_write_data,
  input  logic                        flush,
  output logic                        stall,
  output logic [ADDR_W-1:0]           bank_addr,
  output logic [DATA_W-1:0]           bank_wdata,
  output logic [NUM_BANKS-1:0]        bank_we,
  input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata,
  output logic                        wb_valid,
  output logic                        wb_wbs,
  output logic [DATA_W-1:0]           wb_mem_data,
  output logic [DATA_W-1:0]           wb_calc_data,
  output logic                        wb_ni,
  output logic                        wb_sel_err
);

  // READ_LAT is at most 7, so three counter bits are always enough.
  localparam int                CNT_W   = 3;
  localparam logic [CNT_W-1:0]  LAT     = CNT_W'(READ_LAT);
  localparam bit                HAS_LAT = (READ_LAT > 0);
  // One extra bit so that NUM_BANKS == 2**SEL_W is representable.
  localparam logic [SEL_W:0]    NB      = (SEL_W+1)'(NUM_BANKS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              wbs;
    logic              wme;
    logic [SEL_W-1:0]  mm;
    logic              wm;
    logic              ni;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
  } m_reg_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  m_reg_t            r_m;

  logic              w_stall;
  logic              w_advance;
  logic              w_ex_load;
  logic              w_m_load;
  logic              w_m_store;
  logic              w_sel_oob;
  logic [DATA_W-1:0] w_rd_data;

  // A flushed op is a bubble, so it can never start a read wait.
  assign w_ex_load = ex_valid & ~flush & ex_wbs & ~ex_wme;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: reset is synchronous, so only clk is in the sensitivity list, and all
  // sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // The completion edge of a load (WAIT, counter 0) is also an accept edge, so
  // a following load re-enters WAIT directly and back-to-back loads never lose
  // a cycle to an IDLE visit.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first so that every path assigns every output and no
    // latch is inferred.
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_ex_load && HAS_LAT) begin
          w_state_next = ST_WAIT;
          w_cnt_next   = LAT;
        end
      end
      ST_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end else if (w_ex_load && HAS_LAT) begin
          w_state_next = ST_WAIT;
          w_cnt_next   = LAT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // Every non-stalled edge both accepts a new op into M and captures the
  // writeback bundle from the op currently in M, so one signal drives both.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_stall = 1'b0;
    if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
      w_stall = 1'b1;
    end
  end

  assign stall     = w_stall;
  assign w_advance = ~w_stall;

  // ---------------------------------------------------------------------------
  // Execute/Memory register; holds (and ignores flush) while stalled.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m <= '0;
    end else if (w_advance) begin
      r_m.valid      <= ex_valid & ~flush;
      r_m.wbs        <= ex_wbs;
      r_m.wme        <= ex_wme;
      r_m.mm         <= ex_mm;
      r_m.wm         <= ex_wm;
      r_m.ni         <= ex_ni;
      r_m.alu_result <= ex_alu_result;
      r_m.write_data <= ex_write_data;
    end
  end

  assign w_m_load  = r_m.valid & r_m.wbs & ~r_m.wme;
  assign w_m_store = r_m.valid & r_m.wme;
  assign w_sel_oob = ({1'b0, r_m.mm} >= NB);

  // Address and store data stay stable for as long as M holds.
  assign bank_addr  = r_m.alu_result[ADDR_W-1:0];
  assign bank_wdata = r_m.write_data;

  // An out-of-range select matches no bank, so no write enable fires.
  always_comb begin
    bank_we = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      bank_we[k] = w_m_store & (r_m.mm == SEL_W'(k));
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (r_m.mm == SEL_W'(k)) begin
        w_rd_data = bank_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Writeback bundle: wb_valid is a one-cycle pulse; other fields hold between
  // captures.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_wbs       <= 1'b0;
      wb_mem_data  <= '0;
      wb_calc_data <= '0;
      wb_ni        <= 1'b0;
      wb_sel_err   <= 1'b0;
    end else if (w_advance) begin
      wb_valid     <= r_m.valid;
      wb_wbs       <= r_m.wbs;
      wb_ni        <= r_m.ni;
      wb_calc_data <= r_m.wm ? r_m.write_data : r_m.alu_result;
      wb_mem_data  <= (w_m_load && !w_sel_oob) ? w_rd_data : '0;
      wb_sel_err   <= (w_m_load | w_m_store) & w_sel_oob;
    end else begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_memory_stage_ctrl
//
// Three instances of memory_stage_ctrl with READ_LAT = 0, 1 and 3 share one
// set of ex_* inputs; `sel` picks which instance is observed. Each bank is a
// read-only pattern RAM whose output follows the bank address after the
// instance's read latency. A transaction-level model tracks when each op is
// accepted and when its writeback is due.
// -----------------------------------------------------------------------------
module tb_memory_stage_ctrl;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int NB = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid, ex_wbs, ex_wme, ex_wm, ex_ni, ex_flush;
  logic [SW-1:0] ex_mm;
  logic [DW-1:0] ex_alu, ex_wd;

  always #5 clk = ~clk;

  logic          stall_a [3];
  logic [AW-1:0] addr_a  [3];
  logic [DW-1:0] wdata_a [3];
  logic [NB-1:0] we_a    [3];
  logic          wbv_a   [3];
  logic          wbs_a   [3];
  logic [DW-1:0] mem_a   [3];
  logic [DW-1:0] calc_a  [3];
  logic          ni_a    [3];
  logic          err_a   [3];

  function automatic int lat_of(input int g);
    return (g == 0) ? 0 : (g == 1) ? 1 : 3;
  endfunction

  // Pattern RAM contents: distinct per bank and per address.
  function automatic logic [15:0] bank_val(input int k, input logic [15:0] a);
    if (k == 1 && a == 16'h0002) return 16'hBEEF;
    return {a[7:0], a[15:8]} ^ 16'(32'h3C5A + k * 32'h1111);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int LAT = lat_of(g);
    logic [NB*DW-1:0] rdata;
    logic [AW-1:0]    apipe [3];
    logic [AW-1:0]    a_eff;

    always @(posedge clk) begin
      apipe[0] <= addr_a[g];
      apipe[1] <= apipe[0];
      apipe[2] <= apipe[1];
    end

    if (LAT == 0) begin : g_comb
      assign a_eff = addr_a[g];
    end else begin : g_pipe
      assign a_eff = apipe[LAT-1];
    end

    always_comb begin
      for (int k = 0; k < NB; k++) rdata[k*DW +: DW] = bank_val(k, a_eff);
    end

    memory_stage_ctrl #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB), .SEL_W(SW), .READ_LAT(LAT)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_wbs(ex_wbs), .ex_wme(ex_wme), .ex_mm(ex_mm),
      .ex_wm(ex_wm), .ex_ni(ex_ni), .ex_alu_result(ex_alu),
      .ex_write_data(ex_wd), .flush(ex_flush),
      .stall(stall_a[g]), .bank_addr(addr_a[g]), .bank_wdata(wdata_a[g]),
      .bank_we(we_a[g]), .bank_rdata(rdata),
      .wb_valid(wbv_a[g]), .wb_wbs(wbs_a[g]), .wb_mem_data(mem_a[g]),
      .wb_calc_data(calc_a[g]), .wb_ni(ni_a[g]), .wb_sel_err(err_a[g])
    );
  end

  // Observed instance
  int            sel = 1;
  logic          d_stall, d_wbv, d_wbs, d_ni, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_mem, d_calc;
  logic [NB-1:0] d_we;

  always_comb begin
    d_stall = stall_a[sel];
    d_addr  = addr_a[sel];
    d_wdata = wdata_a[sel];
    d_we    = we_a[sel];
    d_wbv   = wbv_a[sel];
    d_wbs   = wbs_a[sel];
    d_mem   = mem_a[sel];
    d_calc  = calc_a[sel];
    d_ni    = ni_a[sel];
    d_err   = err_a[sel];
  end

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------------------
  // Reference model (transaction level)
  // ---------------------------------------------------------------------------
  int            lat;
  int            edge_n, next_acc, pend_edge;
  bit            pend, accepted, m_valid;
  logic [DW-1:0] m_alu, m_wd;
  logic          p_wbs, p_ni, p_err;
  logic [DW-1:0] p_calc, p_mem;
  bit            exp_wbv, exp_stall;
  logic          e_wbs, e_ni, e_err;
  logic [DW-1:0] e_calc, e_mem;
  logic [NB-1:0] exp_we;

  task automatic model_reset();
    edge_n   = 0;
    next_acc = 0;
    pend     = 0;
    accepted = 0;
    m_valid  = 0;
  endtask

  // One clock edge: predict what it does, then move to the falling edge.
  task automatic advance();
    bit acc, v, ld, st, oob;
    acc = (edge_n + 1 >= next_acc);
    @(posedge clk);
    edge_n++;
    exp_wbv = 0;
    if (pend && pend_edge == edge_n) begin
      exp_wbv = 1;
      e_wbs = p_wbs; e_ni = p_ni; e_err = p_err; e_calc = p_calc; e_mem = p_mem;
      pend = 0;
    end
    exp_we   = '0;
    accepted = acc;
    if (acc) begin
      v   = ex_valid & ~ex_flush;
      st  = v & ex_wme;
      ld  = v & ex_wbs & ~ex_wme;
      oob = (int'(ex_mm) >= NB);
      m_valid = v;
      m_alu   = ex_alu;
      m_wd    = ex_wd;
      if (st && !oob) exp_we = NB'(1 << ex_mm);
      next_acc = (ld && lat > 0) ? edge_n + lat + 1 : edge_n + 1;
      if (v) begin
        pend      = 1;
        pend_edge = ld ? edge_n + lat + 1 : edge_n + 1;
        p_wbs     = ex_wbs;
        p_ni      = ex_ni;
        p_calc    = ex_wm ? ex_wd : ex_alu;
        p_mem     = (ld && !oob) ? bank_val(int'(ex_mm), ex_alu) : '0;
        p_err     = (ld | st) & oob;
      end
    end
    exp_stall = (edge_n + 1 < next_acc);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, wbs, wme, input logic [SW-1:0] mm,
                       input logic wm, ni, input logic [DW-1:0] alu, wd);
    ex_valid = v; ex_wbs = wbs; ex_wme = wme; ex_mm = mm;
    ex_wm = wm; ex_ni = ni; ex_alu = alu; ex_wd = wd; ex_flush = 1'b0;
  endtask

  task automatic bubble();
    drive(0, 0, 0, 2'd0, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic do_reset(input int s);
    sel   = s;
    lat   = lat_of(s);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic rand_op();
    drive($urandom_range(0, 6) != 0, 1'($urandom), $urandom_range(0, 3) == 0,
          2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
          16'($urandom), 16'($urandom));
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drive(1, 1, 0, 2'd1, 0, 0, 16'h0002, 16'h0);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      total++;
      if ({stall_a[g], we_a[g], wbv_a[g], wbs_a[g], ni_a[g], err_a[g], mem_a[g], calc_a[g]} !== '0) begin
        bad++;
        $display("FAIL reset_outputs inst=%0d stall=%b we=%b wbv=%b wbs=%b ni=%b err=%b mem=%h calc=%h want all zero",
                 g, stall_a[g], we_a[g], wbv_a[g], wbs_a[g], ni_a[g], err_a[g], mem_a[g], calc_a[g]);
      end
    end
    // Load in flight abandoned by reset.
    do_reset(2);
    advance();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({d_stall, d_wbv} !== 2'b00) begin
      bad++;
      $display("FAIL reset_abort stall=%b wbv=%b want 0 0", d_stall, d_wbv);
    end
    // First op after release is processed normally.
    sel   = 1;
    lat   = 1;
    rst_n = 1'b1;
    model_reset();
    advance();
    advance();
    bubble();
    advance();
    total++;
    if ({d_wbv, d_mem} !== {1'b1, 16'hBEEF}) begin
      bad++;
      $display("FAIL reset_first_op wbv=%b mem=%h want 1 beef", d_wbv, d_mem);
    end
  endtask

  task automatic test_load();
    do_reset(1);
    drive(1, 1, 0, 2'd1, 0, 1, 16'h0002, 16'h0);
    advance();
    total++;
    if ({d_stall, d_addr, d_wbv} !== {1'b1, 16'h0002, 1'b0}) begin
      bad++;
      $display("FAIL load_e1 stall=%b addr=%h wbv=%b want 1 0002 0", d_stall, d_addr, d_wbv);
    end
    advance();
    total++;
    if ({d_stall, d_wbv} !== 2'b00) begin
      bad++;
      $display("FAIL load_stall_len stall=%b wbv=%b want 0 0", d_stall, d_wbv);
    end
    bubble();
    advance();
    total++;
    if ({d_wbv, d_wbs, d_ni, d_mem} !== {3'b111, 16'hBEEF}) begin
      bad++;
      $display("FAIL load_wb wbv=%b wbs=%b ni=%b mem=%h want 1 1 1 beef", d_wbv, d_wbs, d_ni, d_mem);
    end
    advance();
    total++;
    if (d_wbv !== 1'b0) begin
      bad++;
      $display("FAIL load_pulse wbv=%b want 0", d_wbv);
    end
  endtask

  task automatic test_store();
    do_reset(1);
    drive(1, 0, 1, 2'd2, 0, 0, 16'h00FF, 16'h1234);
    advance();
    total++;
    if ({d_we, d_wdata, d_addr, d_stall} !== {3'b100, 16'h1234, 16'h00FF, 1'b0}) begin
      bad++;
      $display("FAIL store_bank we=%b wdata=%h addr=%h stall=%b want 100 1234 00ff 0", d_we, d_wdata, d_addr, d_stall);
    end
    bubble();
    advance();
    total++;
    if ({d_wbv, d_we, d_err} !== {1'b1, 3'b000, 1'b0}) begin
      bad++;
      $display("FAIL store_wb wbv=%b we=%b err=%b want 1 000 0", d_wbv, d_we, d_err);
    end
  endtask

  task automatic test_calc();
    do_reset(1);
    drive(1, 0, 0, 2'd0, 1, 0, 16'hFF00, 16'h00FF);
    advance();
    drive(1, 0, 0, 2'd0, 0, 0, 16'hFF00, 16'h00FF);
    advance();
    total++;
    if ({d_wbv, d_calc, d_stall} !== {1'b1, 16'h00FF, 1'b0}) begin
      bad++;
      $display("FAIL calc_wm1 wbv=%b calc=%h stall=%b want 1 00ff 0", d_wbv, d_calc, d_stall);
    end
    bubble();
    advance();
    total++;
    if ({d_wbv, d_calc} !== {1'b1, 16'hFF00}) begin
      bad++;
      $display("FAIL calc_wm0 wbv=%b calc=%h want 1 ff00", d_wbv, d_calc);
    end
  endtask

  task automatic test_lat0();
    do_reset(0);
    drive(1, 1, 0, 2'd0, 0, 0, 16'h0007, 16'h0);
    advance();
    total++;
    if (d_stall !== 1'b0) begin
      bad++;
      $display("FAIL lat0_stall stall=%b want 0", d_stall);
    end
    bubble();
    advance();
    total++;
    if ({d_wbv, d_mem} !== {1'b1, bank_val(0, 16'h0007)}) begin
      bad++;
      $display("FAIL lat0_wb wbv=%b mem=%h want 1 %h", d_wbv, d_mem, bank_val(0, 16'h0007));
    end
  endtask

  task automatic test_back_to_back();
    int e0, idx, stall_cnt, we_cnt;
    int            wbe [$];
    logic [DW-1:0] wbm [$];
    logic          wbw [$];
    do_reset(2);
    idx = 0; e0 = 0; stall_cnt = 0; we_cnt = 0;
    drive(1, 1, 0, 2'd0, 0, 0, 16'h0010, 16'h0);
    for (int c = 0; c < 14; c++) begin
      advance();
      if (accepted && idx < 3) begin
        if (idx == 0) e0 = edge_n;
        idx++;
        case (idx)
          1: drive(1, 1, 0, 2'd1, 0, 0, 16'h0020, 16'h0);
          2: drive(1, 0, 1, 2'd0, 0, 0, 16'h0030, 16'hCAFE);
          default: bubble();
        endcase
      end
      if (d_stall) stall_cnt++;
      if (d_we == 3'b001) we_cnt++;
      if (d_wbv) begin
        wbe.push_back(edge_n - e0);
        wbm.push_back(d_mem);
        wbw.push_back(d_wbs);
      end
    end
    total++;
    if (wbe.size() != 3) begin
      bad++;
      $display("FAIL b2b_count got=%0d want 3", wbe.size());
    end else begin
      total++;
      if (wbe[0] != 4 || wbe[1] != 8 || wbe[2] != 9) begin
        bad++;
        $display("FAIL b2b_timing got=E%0d,E%0d,E%0d want E4,E8,E9", wbe[0], wbe[1], wbe[2]);
      end
      total++;
      if ({wbm[0], wbm[1], wbw[2]} !== {bank_val(0, 16'h0010), bank_val(1, 16'h0020), 1'b0}) begin
        bad++;
        $display("FAIL b2b_data got=%h %h wbs=%b want %h %h 0", wbm[0], wbm[1], wbw[2],
                 bank_val(0, 16'h0010), bank_val(1, 16'h0020));
      end
    end
    total++;
    if (stall_cnt != 6 || we_cnt != 1) begin
      bad++;
      $display("FAIL b2b_stall_we stall_cycles=%0d we_cycles=%0d want 6 1", stall_cnt, we_cnt);
    end
  endtask

  task automatic test_edge_cases();
    // Out-of-range bank select on a load.
    do_reset(1);
    drive(1, 1, 0, 2'd3, 0, 0, 16'h0005, 16'h0);
    advance();
    total++;
    if (d_we !== 3'b000) begin
      bad++;
      $display("FAIL oob_we we=%b want 000", d_we);
    end
    advance();
    bubble();
    advance();
    total++;
    if ({d_wbv, d_err, d_mem} !== {1'b1, 1'b1, 16'h0000}) begin
      bad++;
      $display("FAIL oob_wb wbv=%b err=%b mem=%h want 1 1 0000", d_wbv, d_err, d_mem);
    end
    // Flush at the accept edge.
    drive(1, 0, 1, 2'd0, 0, 0, 16'h0011, 16'h2222);
    ex_flush = 1'b1;
    advance();
    total++;
    if ({d_we, d_stall} !== 4'b0000) begin
      bad++;
      $display("FAIL flush_accept we=%b stall=%b want 000 0", d_we, d_stall);
    end
    bubble();
    advance();
    total++;
    if (d_wbv !== 1'b0) begin
      bad++;
      $display("FAIL flush_wb wbv=%b want 0", d_wbv);
    end
    // Flush while stalled is ignored.
    do_reset(2);
    drive(1, 1, 0, 2'd2, 0, 0, 16'h0044, 16'h0);
    advance();
    ex_flush = 1'b1;
    advance();
    advance();
    advance();
    total++;
    if (d_stall !== 1'b0) begin
      bad++;
      $display("FAIL flush_stall_len stall=%b want 0", d_stall);
    end
    bubble();
    advance();
    total++;
    if ({d_wbv, d_mem} !== {1'b1, bank_val(2, 16'h0044)}) begin
      bad++;
      $display("FAIL flush_in_stall wbv=%b mem=%h want 1 %h", d_wbv, d_mem, bank_val(2, 16'h0044));
    end
  endtask

  task automatic test_random(input int s, input int cycles);
    do_reset(s);
    rand_op();
    for (int c = 0; c < cycles; c++) begin
      advance();
      total++;
      if ({d_stall, d_we, d_wbv} !== {exp_stall, exp_we, exp_wbv}) begin
        bad++;
        $display("FAIL rnd_ctrl lat=%0d edge=%0d stall=%b we=%b wbv=%b want %b %b %b",
                 lat, edge_n, d_stall, d_we, d_wbv, exp_stall, exp_we, exp_wbv);
      end
      if (exp_wbv) begin
        total++;
        if ({d_wbs, d_ni, d_err, d_calc, d_mem} !== {e_wbs, e_ni, e_err, e_calc, e_mem}) begin
          bad++;
          $display("FAIL rnd_wb lat=%0d edge=%0d wbs=%b ni=%b err=%b calc=%h mem=%h want %b %b %b %h %h",
                   lat, edge_n, d_wbs, d_ni, d_err, d_calc, d_mem, e_wbs, e_ni, e_err, e_calc, e_mem);
        end
      end
      if (m_valid) begin
        total++;
        if ({d_addr, d_wdata} !== {m_alu, m_wd}) begin
          bad++;
          $display("FAIL rnd_bus lat=%0d edge=%0d addr=%h wdata=%h want %h %h",
                   lat, edge_n, d_addr, d_wdata, m_alu, m_wd);
        end
      end
      if (accepted) rand_op();
      ex_flush = ($urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    bubble();
    test_reset();
    test_load();
    test_store();
    test_calc();
    test_lat0();
    test_back_to_back();
    test_edge_cases();
    test_random(0, 300);
    test_random(1, 300);
    test_random(2, 300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_stage_ctrl.md
Name: memory_stage_ctrl

Overview:
- Parametrised memory stage for the 16-bit pipelined CPU, placed between the execute stage and writeback.
- Contains the Execute/Memory pipeline register and a bank decoder over NUM_BANKS synchronous RAMs (coordinates, pixel and general data).
- Tracks configurable read latency, stalling upstream and flushing as needed, and produces the registered writeback bundle.
- Replaces the fixed three-output decoder and two-register arrangement.

Parameters:
DATA_W, 16, datapath width of ALU result, store data and bank read data
ADDR_W, 16, bank address width; address = ex_alu_result[ADDR_W-1:0]
NUM_BANKS, 3, number of attached RAM banks (1..8)
SEL_W, 2, width of bank select; must satisfy 2**SEL_W >= NUM_BANKS
READ_LAT, 1, cycles from stable bank_addr to valid bank_rdata (0..7)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
ex_valid  in  1  execute stage presents an operation
ex_wbs  in  1  writeback select: 1 = load (memory data), 0 = calc data
ex_wme  in  1  memory write enable (store)
ex_mm  in  SEL_W  bank select
ex_wm  in  1  calc mux select: 1 = ex_write_data, 0 = ex_alu_result
ex_ni  in  1  next-instruction flag, passed through
ex_alu_result  in  DATA_W  address / ALU result
ex_write_data  in  DATA_W  store data
flush  in  1  turn the operation accepted this edge into a bubble
stall  out  1  upstream must hold ex_* stable
bank_addr  out  ADDR_W  shared address to all banks
bank_wdata  out  DATA_W  shared store data
bank_we  out  NUM_BANKS  one-hot write enable
bank_rdata  in  NUM_BANKS*DATA_W  concatenated read data; bank k = slice k
wb_valid  out  1  writeback bundle valid
wb_wbs  out  1  registered ex_wbs
wb_mem_data  out  DATA_W  loaded data
wb_calc_data  out  DATA_W  muxed calc data
wb_ni  out  1  registered ex_ni
wb_sel_err  out  1  access targeted ex_mm >= NUM_BANKS

Behaviour:
- Reset (rst_n=0 at an edge) clears the following: state=IDLE, counter=0, M register valid=0 and all M fields=0. All wb_* outputs, stall and bank_we are 0.
- Reset wins over every other event. A load in flight is abandoned with no writeback.
- Op classes:
  - load = valid & wbs & ~wme
  - store = valid & wme (wme has priority over wbs)
  - other = valid, neither load nor store
- Accept edge: any edge with stall=0. At that edge M <= ex_* with M.valid = ex_valid & ~flush.
- While stall=1, M holds its contents and flush is ignored.
- bank_addr and bank_wdata come combinationally from M, and stay stable for as long as M holds.
- bank_we[k] = M.valid & M.wme & (M.mm==k). It is high for exactly the one cycle after acceptance.
- If M.mm >= NUM_BANKS, bank_we is 0.
- FSM has two states, IDLE and WAIT:
  - IDLE to WAIT: at an accept edge where the captured op is a load and READ_LAT>0. Counter <= READ_LAT.
  - WAIT: counter decrements each edge.
  - WAIT to IDLE: at the edge where counter==0. WB captures at that edge.
- stall = (state==WAIT) & (counter!=0).
- A new op may be accepted on the same edge as load completion, so back-to-back loads cost READ_LAT+1 cycles each.
- Latency from accept edge E0 to WB update:
  - non-load: E1.
  - load: E0+READ_LAT+1 edges.
  - READ_LAT=0 means combinational read: load captured at E1 with no stall.
- WB capture:
  - wb_valid <= M.valid; wb_wbs, wb_ni come from M.
  - wb_calc_data <= M.wm ? M.write_data : M.alu_result.
  - wb_mem_data <= bank_rdata slice M.mm for loads with mm in range, otherwise 0.
  - wb_sel_err <= M.valid & (load|store) & (M.mm >= NUM_BANKS).
- Edges that are not WB capture edges: if state==IDLE and the edge is not a capture edge, wb_valid <= 0 (the bundle is one cycle wide). During WAIT, wb_valid stays 0.
- A bubble (ex_valid=0 or flushed) produces wb_valid=0 and no bank access.

Test Plan:
- Reset: rst_n=0 for 2 edges with ex_valid=1 load -> wb_*=0, stall=0, bank_we=0. First op after release is processed normally.
- Load, READ_LAT=1, alu_result=0x0002, mm=1, bank1 returns 0xBEEF -> stall high exactly 1 cycle, bank_addr=0x0002; wb_mem_data=0xBEEF, wb_valid=1 at E2.
- Store, mm=2, alu_result=0x00FF, write_data=0x1234 -> bank_we=3'b100 for one cycle, bank_wdata=0x1234. At E1: wb_valid=1, no stall.
- Calc op, wm=1, alu_result=0xFF00, write_data=0x00FF -> wb_calc_data=0x00FF at E1. Same op with wm=0 -> 0xFF00.
- Back-to-back: load, load, store with READ_LAT=3 -> each load stalls 3 cycles. WB updates at E4 and E8, the store at E9, and no op is dropped or duplicated.
- Edge cases:
  - mm=3 with NUM_BANKS=3 load -> wb_sel_err=1, wb_mem_data=0, bank_we=0.
  - flush at accept edge -> wb_valid=0.
  - flush during stall -> ignored, load completes.
